// File: rtl/cnn_pkg.sv
// Shared CNN constants and the unpool frame-sequencing state type.
package cnn_pkg;
  localparam int DATA_W = 32;
  localparam int FM_W   = 3;
  localparam int FM_H   = 3;
  // Output row/col index width; holds 0..2*FM-1 for the default map.
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_STREAM,
    ST_DONE
  } unpool_state_e;
endpackage

// File: rtl/unpool_addr_gen.sv
// Raster row/column walker over the 2x upsampled output map.
module unpool_addr_gen #(
  parameter int IN_W = cnn_pkg::FM_W,
  parameter int IN_H = cnn_pkg::FM_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      advance,
  input  logic                      clear,
  output logic [cnn_pkg::CNT_W-1:0] row,
  output logic [cnn_pkg::CNT_W-1:0] col,
  output logic                      last
);
  import cnn_pkg::*;

  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(2*IN_H-1);
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(2*IN_W-1);

  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;

  // Next position: clear wins, otherwise step col and wrap into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);
endmodule

// File: rtl/unpool_layer.sv
// 2x2 unpooling: snapshots one input map and streams the upsampled map
// in raster order, replicating or distributing (value/4) each pixel.
module unpool_layer #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IN_W   = cnn_pkg::FM_W,
  parameter int IN_H   = cnn_pkg::FM_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [IN_W*IN_H*DATA_W-1:0] input_fm,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               out_row,
  output logic [2:0]               out_col,
  output logic                     out_last,
  output logic                     done
);
  import cnn_pkg::*;

  localparam int NPIX  = IN_W*IN_H;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  unpool_state_e state_q, state_d;
  logic signed [DATA_W-1:0] buf_q [NPIX];
  logic signed [DATA_W-1:0] buf_d [NPIX];
  logic                     mode_q, mode_d;

  logic [2:0]               row, col;
  logic                     last, advance, clear, accept;
  logic [IDX_W-1:0]         src_idx;
  logic signed [DATA_W-1:0] src_pix;

  assign accept    = (state_q == ST_IDLE) && start;
  assign out_valid = (state_q == ST_STREAM);
  assign advance   = out_valid && out_ready;
  assign clear     = (state_q == ST_CAPTURE);

  // Frame sequencing; start outside IDLE (including DONE) is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_STREAM;
      ST_STREAM:  if (advance && last) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot the map and mode on the accepting edge only.
  always_comb begin
    buf_d  = buf_q;
    mode_d = mode_q;
    if (accept) begin
      for (int k = 0; k < NPIX; k++) buf_d[k] = input_fm[k*DATA_W +: DATA_W];
      mode_d = mode;
    end
  end

  // Snapshot storage; contents are don't-care until the next capture.
  always_ff @(posedge clk) begin
    buf_q  <= buf_d;
    mode_q <= mode_d;
  end

  unpool_addr_gen #(.IN_W(IN_W), .IN_H(IN_H)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .advance(advance),
    .clear  (clear),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  // Each input pixel covers a 2x2 output block.
  assign src_idx = IDX_W'((32'(row) >> 1) * 32'(IN_W) + (32'(col) >> 1));
  assign src_pix = buf_q[src_idx];

  // Output pixel, forced to zero whenever nothing is being presented.
  always_comb begin
    out_data = '0;
    if (out_valid) out_data = mode_q ? (src_pix >>> 2) : src_pix;
  end

  assign out_row  = row;
  assign out_col  = col;
  assign out_last = last && out_valid;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_unpool_layer.sv
// Scoreboard bench for unpool_layer: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every transfer.
module tb_unpool_layer;
  localparam int DW = 32;
  localparam int NP = 9;
  localparam int NO = 36;

  logic clk = 1'b0;
  logic rst, start, mode, out_ready;
  logic [NP*DW-1:0] input_fm;
  logic busy, out_valid, out_last, done;
  logic [DW-1:0] out_data;
  logic [2:0] out_row, out_col;

  always #5 clk = ~clk;

  unpool_layer #(.DATA_W(DW), .IN_W(3), .IN_H(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .input_fm(input_fm),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  logic [3:0] pat = 4'b1001;

  // Hand-computed input maps and the value each input pixel should produce.
  int v_rep[NP]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int v_m7[NP]   = '{-7, -7, -7, -7, -7, -7, -7, -7, -7};
  int e_m7[NP]   = '{-2, -2, -2, -2, -2, -2, -2, -2, -2};
  int v_mix[NP]  = '{100, -7, -1, 4, -8, 3, 0, -100, 7};
  int e_mix[NP]  = '{25, -2, -1, 1, -2, 0, 0, -25, 1};
  int v_ten[NP]  = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
  int v_chg[NP]  = '{-3, 12, -12, 5, -5, 16, 1, -16, 8};
  int e_chg[NP]  = '{-1, 3, -3, 1, -2, 4, 0, -4, 2};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [NP*DW-1:0] pack_fm(input int v[NP]);
    logic [NP*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NP; k++) r[k*DW +: DW] = v[k];
    return r;
  endfunction

  task automatic push_frame(input int ev[NP]);
    exp_t e;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        e.data = ev[(r/2)*3 + (c/2)];
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.last = (r == 5) && (c == 5);
        q.push_back(e);
      end
  endtask

  // Monitor: compare every transfer against the queue, and hold-stability on stalls.
  initial begin
    exp_t e;
    logic [39:0] prev, now;
    bit prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      now = {out_valid, out_data, out_row, out_col, out_last};
      if (prev_stall) chk("stall_hold", longint'(now), longint'(prev));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data", $signed(out_data), $signed(e.data));
          chk("row", out_row, e.row);
          chk("col", out_col, e.col);
          chk("last", out_last, e.last);
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev = now;
    end
  end

  task automatic start_frame(input int iv[NP], input logic m);
    xfer_cnt = 0;
    @(posedge clk); #1;
    input_fm = pack_fm(iv);
    mode = m;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int iv[NP], input int ev[NP], input logic m,
                           input bit bp, input bit mid_start, input bit change_fm,
                           input bit start_in_done);
    bit got;
    push_frame(ev);
    start_frame(iv, m);
    if (change_fm) begin
      input_fm = ~pack_fm(iv);
      mode = ~m;
    end
    @(negedge clk);
    chk("capture_busy", busy, 1);
    chk("capture_valid", out_valid, 0);
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      out_ready = bp ? pat[k % 4] : 1'b1;
      if (mid_start && k == 5) begin
        input_fm = pack_fm(v_m7);
        start = 1'b1;
      end else if (mid_start && k == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("first_valid", out_valid, 1);
        chk("first_row", out_row, 0);
        chk("first_col", out_col, 0);
      end
      if (done) got = 1;
      else chk("busy_in_frame", busy, 1);
    end
    chk("done_seen", got, 1);
    chk("xfer_count", xfer_cnt, NO);
    chk("queue_empty", q.size(), 0);
    chk("done_gap", cyc - last_xfer_cyc, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", out_valid, 0);
    if (!bp) chk("no_gaps", last_xfer_cyc - first_xfer_cyc, NO - 1);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    q.delete();
  endtask

  task automatic reset_mid_frame();
    bit hit;
    push_frame(v_rep);
    start_frame(v_rep, 1'b0);
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk); #1;
      if (xfer_cnt == 9) hit = 1;
    end
    chk("reached_pixel10", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_data", out_data, 0);
    q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    out_ready = 1'b1;
    input_fm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_last", out_last, 0);
    chk("reset_row", out_row, 0);
    chk("reset_col", out_col, 0);
    chk("reset_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(v_rep, v_rep, 1'b0, 0, 0, 0, 0);   // replicate
    run_frame(v_rep, v_rep, 1'b0, 1, 0, 0, 0);   // backpressure 1,0,0,1
    run_frame(v_m7,  e_m7,  1'b1, 0, 0, 0, 0);   // distribute -7
    run_frame(v_mix, e_mix, 1'b1, 0, 0, 0, 0);   // distribute mixed, 100 -> 25
    run_frame(v_ten, v_ten, 1'b0, 0, 1, 0, 0);   // start during stream ignored
    run_frame(v_chg, e_chg, 1'b1, 0, 0, 1, 1);   // snapshot + start in DONE
    reset_mid_frame();
    run_frame(v_rep, v_rep, 1'b0, 0, 0, 0, 0);   // fresh frame after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
